cfg_byte_deframer: RTL and testbench
====================================

CFG_BYTE_DEFRAMER -- requirements
Module: cfg_byte_deframer

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 4, giving bytes per configuration word (legal 2..8); WORD_W = 8*WORD_BYTES.
REQ-002 The block SHALL have parameter SYNC_WORD, default 32'h00AAFF01, WORD_W bits, as the primary sync pattern.
REQ-003 The block SHALL have parameter SYNC_WORD_ALT, default 32'h00AAFF02, WORD_W bits, as the alternate sync pattern.
REQ-004 The block SHALL have parameter DESYNC_WORD, default 32'h0010_0000, WORD_W bits, as the end-of-bitstream word.
REQ-005 The block SHALL have parameter ACK_WORD, default 32'hFAB0_FABF, WORD_W bits, as the acknowledge frame.
REQ-006 The block SHALL have parameter ACK_EN, default 1, where 1 sends the acknowledge after desync and 0 skips it.
REQ-007 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the inter-byte timeout in RECEIVE (0 disables; counter 32 bits).
REQ-008 The block SHALL have the following ports:
  clk_i  in  1  clock
  reset_n_i  in  1  reset, asynchronous, active-low
  out_data_i  in  8  host-to-device byte
  out_valid_i  in  1  out_data_i valid
  out_ready_o  out  1  byte consumed when out_valid_i && out_ready_o
  in_data_o  out  8  device-to-host byte
  in_valid_o  out  1  in_data_o valid
  in_ready_i  in  1  byte consumed when in_valid_o && in_ready_i
  word_write_strobe_o  out  1  one-cycle word strobe
  write_data_o  out  WORD_W  assembled word
  sync_o  out  1  high while in RECEIVE
  word_count_o  out  16  words written since last sync, saturating
  timeout_o  out  1  one-cycle pulse on timeout abort

Function
REQ-009 The block SHALL implement states HUNT, RECEIVE and ACK with a registered state.
REQ-010 A byte SHALL be accepted only in a cycle where out_valid_i && out_ready_o.
REQ-011 out_ready_o SHALL be 1 in HUNT and RECEIVE and 0 in ACK.
REQ-012 Each accepted byte SHALL shift into the WORD_W shift register at the LSB end, making the word MSB-first.
REQ-013 In HUNT, if the post-shift register equals SYNC_WORD or SYNC_WORD_ALT, the block SHALL enter RECEIVE next cycle with byte counter 0 and word_count_o 0; the sync word itself SHALL NOT be written.
REQ-014 In RECEIVE, the byte counter SHALL increment per accepted byte and wrap at WORD_BYTES-1 to 0.
REQ-015 On acceptance of the last byte of a word in cycle N, write_data_o SHALL take the assembled word in cycle N+1 with word_write_strobe_o high for exactly that cycle, and word_count_o SHALL increment, saturating at 16'hFFFF.
REQ-016 write_data_o SHALL hold its last value between strobes.
REQ-017 When the word written equals DESYNC_WORD, it SHALL still be strobed, and the state SHALL go to ACK if ACK_EN=1, else to HUNT, in cycle N+1.
REQ-018 In ACK, in_valid_o SHALL be 1 and in_data_o SHALL present ACK_WORD bytes MSB first, holding each byte stable until in_ready_i, then advancing next cycle.
REQ-019 After the last ACK byte is consumed, the state SHALL return to HUNT and in_valid_o SHALL be 0 next cycle.
REQ-020 On every entry to HUNT the shift register SHALL clear to 0, so a stale sync cannot re-match.
REQ-021 In RECEIVE with TIMEOUT_CYCLES>0, the idle counter SHALL clear on each accepted byte; on reaching TIMEOUT_CYCLES-1 the partial word SHALL be discarded, the state SHALL go to HUNT and timeout_o SHALL pulse one cycle.
REQ-022 If a byte is accepted in the same cycle the timeout is reached, the acceptance SHALL win and no timeout SHALL occur.
REQ-023 The sync pattern SHALL NOT be recognised inside RECEIVE; only DESYNC_WORD or a timeout leaves RECEIVE.
REQ-024 in_valid_o SHALL be 0 outside ACK.

Reset
REQ-025 Asserting reset_n_i at any time, including mid-word or mid-ACK, SHALL immediately force: state HUNT, shift register 0, counters 0, in_valid_o 0, in_data_o 8'h00, word_write_strobe_o 0, write_data_o 0, sync_o 0, word_count_o 0, timeout_o 0.

Verification
REQ-026 Bytes 00 AA FF 01 then 12 34 56 78 -> sync_o 1 after byte 4; one strobe with write_data_o 32'h12345678; word_count_o 1.
REQ-027 After sync, send 00 10 00 00 with in_ready_i held 0 for 5 cycles, then 1 -> strobe 32'h00100000; in_data_o FA held stable while stalled, then B0, FA, BF; then HUNT with out_ready_o 1.
REQ-028 Bytes AA 00 AA FF 02 (garbage prefix) -> sync on byte 5; bytes 00 AA FF 01 sent in RECEIVE -> strobed as data 32'h00AAFF01, no resync.
REQ-029 TIMEOUT_CYCLES=16: sync, 2 data bytes, idle 16 cycles -> timeout_o pulse, sync_o 0, no strobe; next 4 bytes are not written until a new sync.
REQ-030 Reset asserted during ACK byte 2 -> in_valid_o 0 immediately; after release, 00 AA FF 01 resyncs normally.
REQ-031 ACK_EN=0, WORD_BYTES=2, SYNC_WORD 16'hAA01, DESYNC_WORD 16'h0010: sync, 00 10 -> strobe 16'h0010, direct return to HUNT, in_valid_o never 1.

Source files
------------

// File: rtl/cfg_byte_deframer.sv
// cfg_byte_deframer
//   Turns a host-to-device byte stream into configuration words. The block
//   hunts for a sync pattern, then assembles MSB-first words and strobes them
//   out. It leaves RECEIVE on the desync word, optionally after sending an
//   acknowledge frame back to the host. An inter-byte timeout also ends
//   RECEIVE.
//
// Ports
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   out_data_i/valid_i    host-to-device byte stream
//   out_ready_o           high in HUNT and RECEIVE, low while acknowledging
//   in_data_o/valid_o     device-to-host acknowledge bytes
//   in_ready_i            host accepts the acknowledge byte
//   word_write_strobe_o   one-cycle strobe per assembled word
//   write_data_o          assembled word, held between strobes
//   sync_o                high while in RECEIVE
//   word_count_o          words written since the last sync, saturating
//   timeout_o             one-cycle pulse when the inter-byte timeout aborts
module cfg_byte_deframer #(
    parameter int unsigned WORD_BYTES = 4,
    localparam int unsigned WORD_W = 8 * WORD_BYTES,
    parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(32'h00AA_FF01),
    parameter logic [WORD_W-1:0] SYNC_WORD_ALT = WORD_W'(32'h00AA_FF02),
    parameter logic [WORD_W-1:0] DESYNC_WORD = WORD_W'(32'h0010_0000),
    parameter logic [WORD_W-1:0] ACK_WORD = WORD_W'(32'hFAB0_FABF),
    parameter bit ACK_EN = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [7:0]        out_data_i,
    input  logic              out_valid_i,
    output logic              out_ready_o,
    output logic [7:0]        in_data_o,
    output logic              in_valid_o,
    input  logic              in_ready_i,
    output logic              word_write_strobe_o,
    output logic [WORD_W-1:0] write_data_o,
    output logic              sync_o,
    output logic [15:0]       word_count_o,
    output logic              timeout_o
);

    localparam logic [2:0] LAST_BYTE = 3'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_RECEIVE,
        ST_ACK
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shift_next;
    logic [2:0]        byte_cnt;
    logic [2:0]        ack_idx;
    logic [31:0]       idle_cnt;
    logic              accept;

    // Byte idx of the acknowledge frame, counted from the MSB end.
    function automatic logic [7:0] ack_byte(input logic [2:0] idx);
        logic [WORD_W-1:0] tmp;
        tmp = ACK_WORD << {idx, 3'b000};
        return tmp[WORD_W-1 -: 8];
    endfunction

    assign out_ready_o = (state != ST_ACK);
    assign sync_o      = (state == ST_RECEIVE);
    assign accept      = out_valid_i && out_ready_o;
    assign shift_next  = {shreg[WORD_W-9:0], out_data_i};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state               <= ST_HUNT;
            shreg               <= '0;
            byte_cnt            <= '0;
            ack_idx             <= '0;
            idle_cnt            <= '0;
            in_valid_o          <= 1'b0;
            in_data_o           <= 8'h00;
            word_write_strobe_o <= 1'b0;
            write_data_o        <= '0;
            word_count_o        <= '0;
            timeout_o           <= 1'b0;
        end else begin
            word_write_strobe_o <= 1'b0;
            timeout_o           <= 1'b0;
            unique case (state)
                ST_HUNT: begin
                    if (accept) begin
                        shreg <= shift_next;
                        if (shift_next == SYNC_WORD || shift_next == SYNC_WORD_ALT) begin
                            state        <= ST_RECEIVE;
                            byte_cnt     <= '0;
                            word_count_o <= '0;
                            idle_cnt     <= '0;
                        end
                    end
                end
                ST_RECEIVE: begin
                    // An accepted byte takes priority over an expiring timeout.
                    if (accept) begin
                        shreg    <= shift_next;
                        idle_cnt <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt            <= '0;
                            write_data_o        <= shift_next;
                            word_write_strobe_o <= 1'b1;
                            if (word_count_o != 16'hFFFF)
                                word_count_o <= word_count_o + 16'd1;
                            if (shift_next == DESYNC_WORD) begin
                                if (ACK_EN) begin
                                    state      <= ST_ACK;
                                    ack_idx    <= '0;
                                    in_valid_o <= 1'b1;
                                    in_data_o  <= ack_byte(3'd0);
                                end else begin
                                    state <= ST_HUNT;
                                    shreg <= '0;
                                end
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (idle_cnt == TIMEOUT_CYCLES - 1) begin
                            state     <= ST_HUNT;
                            shreg     <= '0;
                            byte_cnt  <= '0;
                            idle_cnt  <= '0;
                            timeout_o <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 32'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (in_ready_i) begin
                        if (ack_idx == LAST_BYTE) begin
                            state      <= ST_HUNT;
                            shreg      <= '0;
                            ack_idx    <= '0;
                            in_valid_o <= 1'b0;
                            in_data_o  <= 8'h00;
                        end else begin
                            ack_idx   <= ack_idx + 3'd1;
                            in_data_o <= ack_byte(ack_idx + 3'd1);
                        end
                    end
                end
                default: begin
                    state <= ST_HUNT;
                    shreg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_byte_deframer.sv
// tb_cfg_byte_deframer
//   Scoreboard bench for cfg_byte_deframer. Instance A uses the default
//   32-bit configuration with a 16-cycle timeout. Instance B is a 16-bit
//   variant with the acknowledge disabled. Expected words and acknowledge
//   bytes are queued as stimulus is driven. Negedge monitors pop the queues
//   and compare.
module tb_cfg_byte_deframer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [7:0]  a_out_data, a_in_data;
    logic        a_out_valid, a_out_ready, a_in_valid, a_in_ready;
    logic        a_strobe, a_sync, a_timeout;
    logic [31:0] a_wdata;
    logic [15:0] a_wcount;

    logic [7:0]  b_out_data, b_in_data;
    logic        b_out_valid, b_out_ready, b_in_valid, b_in_ready;
    logic        b_strobe, b_sync, b_timeout;
    logic [15:0] b_wdata;
    logic [15:0] b_wcount;

    logic [31:0] a_wq[$];
    logic [7:0]  a_aq[$];
    logic [15:0] b_wq[$];

    int n_vec  = 0;
    int n_miss = 0;

    cfg_byte_deframer #(
        .WORD_BYTES(4),
        .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk_i(clk), .reset_n_i(reset_n),
        .out_data_i(a_out_data), .out_valid_i(a_out_valid), .out_ready_o(a_out_ready),
        .in_data_o(a_in_data), .in_valid_o(a_in_valid), .in_ready_i(a_in_ready),
        .word_write_strobe_o(a_strobe), .write_data_o(a_wdata), .sync_o(a_sync),
        .word_count_o(a_wcount), .timeout_o(a_timeout)
    );

    cfg_byte_deframer #(
        .WORD_BYTES(2),
        .SYNC_WORD(16'hAA01),
        .SYNC_WORD_ALT(16'hAA02),
        .DESYNC_WORD(16'h0010),
        .ACK_WORD(16'hFABF),
        .ACK_EN(1'b0)
    ) dut_b (
        .clk_i(clk), .reset_n_i(reset_n),
        .out_data_i(b_out_data), .out_valid_i(b_out_valid), .out_ready_o(b_out_ready),
        .in_data_o(b_in_data), .in_valid_o(b_in_valid), .in_ready_i(b_in_ready),
        .word_write_strobe_o(b_strobe), .write_data_o(b_wdata), .sync_o(b_sync),
        .word_count_o(b_wcount), .timeout_o(b_timeout)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All drive tasks run in the posedge+1 phase.
    task automatic send_a(input logic [7:0] b);
        a_out_data  = b;
        a_out_valid = 1'b1;
        @(posedge clk); #1;
        a_out_valid = 1'b0;
    endtask

    task automatic send_a_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_a(w[8*i +: 8]);
    endtask

    task automatic send_b(input logic [7:0] b);
        b_out_data  = b;
        b_out_valid = 1'b1;
        @(posedge clk); #1;
        b_out_valid = 1'b0;
    endtask

    task automatic push_ack();
        a_aq.push_back(8'hFA);
        a_aq.push_back(8'hB0);
        a_aq.push_back(8'hFA);
        a_aq.push_back(8'hBF);
    endtask

    task automatic wait_ack_done();
        for (int i = 0; i < 40 && a_in_valid; i++) begin
            @(posedge clk); #1;
        end
        check_val("ack_done_in_valid", 64'(a_in_valid), 64'(0));
        check_val("ack_done_out_ready", 64'(a_out_ready), 64'(1));
    endtask

    // Word scoreboard for instance A.
    always @(negedge clk) begin
        if (a_strobe) begin
            if (a_wq.size() == 0) check_val("a_strobe_unexpected", 64'(a_strobe), 64'(0));
            else check_val("a_word", 64'(a_wdata), 64'(a_wq.pop_front()));
        end
    end

    // Acknowledge scoreboard for instance A, checked at each handshake.
    always @(negedge clk) begin
        if (a_in_valid && a_in_ready) begin
            if (a_aq.size() == 0) check_val("a_ack_unexpected", 64'(a_in_valid), 64'(0));
            else check_val("a_ack_byte", 64'(a_in_data), 64'(a_aq.pop_front()));
        end
    end

    // Instance B: word scoreboard, plus in_valid must never rise.
    always @(negedge clk) begin
        if (b_strobe) begin
            if (b_wq.size() == 0) check_val("b_strobe_unexpected", 64'(b_strobe), 64'(0));
            else check_val("b_word", 64'(b_wdata), 64'(b_wq.pop_front()));
        end
        if (reset_n) check_val("b_in_valid", 64'(b_in_valid), 64'(0));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset_n     = 1'b0;
        a_out_data  = 8'h00; a_out_valid = 1'b0; a_in_ready = 1'b0;
        b_out_data  = 8'h00; b_out_valid = 1'b0; b_in_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_valid", 64'(a_in_valid), 64'(0));
        check_val("rst_in_data", 64'(a_in_data), 64'(0));
        check_val("rst_strobe", 64'(a_strobe), 64'(0));
        check_val("rst_wdata", 64'(a_wdata), 64'(0));
        check_val("rst_sync", 64'(a_sync), 64'(0));
        check_val("rst_wcount", 64'(a_wcount), 64'(0));
        check_val("rst_timeout", 64'(a_timeout), 64'(0));
        check_val("rst_out_ready", 64'(a_out_ready), 64'(1));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Primary sync, then one data word.
        send_a(8'h00); send_a(8'hAA); send_a(8'hFF);
        check_val("t1_sync_before", 64'(a_sync), 64'(0));
        send_a(8'h01);
        check_val("t1_sync_after", 64'(a_sync), 64'(1));
        check_val("t1_wcount0", 64'(a_wcount), 64'(0));
        a_wq.push_back(32'h1234_5678);
        send_a_word(32'h1234_5678);
        check_val("t1_strobe", 64'(a_strobe), 64'(1));
        check_val("t1_wdata", 64'(a_wdata), 64'(32'h1234_5678));
        check_val("t1_wcount1", 64'(a_wcount), 64'(1));
        @(posedge clk); #1;
        check_val("t1_strobe_low", 64'(a_strobe), 64'(0));
        check_val("t1_wdata_hold", 64'(a_wdata), 64'(32'h1234_5678));

        // Desync with a stalled acknowledge.
        a_in_ready = 1'b0;
        a_wq.push_back(32'h0010_0000);
        push_ack();
        send_a_word(32'h0010_0000);
        check_val("t2_strobe", 64'(a_strobe), 64'(1));
        check_val("t2_out_ready", 64'(a_out_ready), 64'(0));
        check_val("t2_sync", 64'(a_sync), 64'(0));
        for (int i = 0; i < 5; i++) begin
            check_val("t2_stall_valid", 64'(a_in_valid), 64'(1));
            check_val("t2_stall_data", 64'(a_in_data), 64'(8'hFA));
            @(posedge clk); #1;
        end
        a_in_ready = 1'b1;
        wait_ack_done();
        check_val("t2_ack_left", 64'(a_aq.size()), 64'(0));

        // Garbage prefix, alternate sync; sync pattern inside RECEIVE is data.
        send_a(8'hAA); send_a(8'h00); send_a(8'hAA); send_a(8'hFF);
        check_val("t3_sync_before", 64'(a_sync), 64'(0));
        send_a(8'h02);
        check_val("t3_sync_after", 64'(a_sync), 64'(1));
        a_wq.push_back(32'h00AA_FF01);
        send_a_word(32'h00AA_FF01);
        check_val("t3_still_sync", 64'(a_sync), 64'(1));
        check_val("t3_wcount", 64'(a_wcount), 64'(1));
        a_wq.push_back(32'h0010_0000);
        push_ack();
        send_a_word(32'h0010_0000);
        check_val("t3_wcount2", 64'(a_wcount), 64'(2));
        wait_ack_done();

        // Reset while the second acknowledge byte is presented.
        a_in_ready = 1'b0;
        send_a_word(32'h00AA_FF01);
        check_val("t5_sync", 64'(a_sync), 64'(1));
        a_wq.push_back(32'h0010_0000);
        send_a_word(32'h0010_0000);
        a_aq.push_back(8'hFA);
        a_in_ready = 1'b1;
        @(posedge clk); #1;
        a_in_ready = 1'b0;
        check_val("t5_ack_byte2", 64'(a_in_data), 64'(8'hB0));
        check_val("t5_ack_valid2", 64'(a_in_valid), 64'(1));
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_in_valid", 64'(a_in_valid), 64'(0));
        check_val("t5_rst_in_data", 64'(a_in_data), 64'(0));
        check_val("t5_rst_wdata", 64'(a_wdata), 64'(0));
        check_val("t5_rst_wcount", 64'(a_wcount), 64'(0));
        check_val("t5_rst_out_ready", 64'(a_out_ready), 64'(1));
        @(posedge clk); #1;
        reset_n = 1'b1;
        send_a_word(32'h00AA_FF01);
        check_val("t5_resync", 64'(a_sync), 64'(1));
        check_val("t5_resync_wcount", 64'(a_wcount), 64'(0));
        a_wq.push_back(32'h0010_0000);
        push_ack();
        a_in_ready = 1'b1;
        send_a_word(32'h0010_0000);
        wait_ack_done();

        // Timeout: a byte on the last idle cycle still wins; then a real abort.
        send_a_word(32'h00AA_FF01);
        repeat (15) begin
            @(posedge clk); #1;
        end
        send_a(8'h00);
        check_val("t4_edge_no_timeout", 64'(a_timeout), 64'(0));
        check_val("t4_edge_sync", 64'(a_sync), 64'(1));
        send_a(8'hAA); send_a(8'hFF);
        cyc = 0;
        while (cyc < 40 && !a_timeout) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("t4_timeout_pulse", 64'(a_timeout), 64'(1));
        check_val("t4_idle_cycles", 64'(cyc), 64'(16));
        check_val("t4_sync_drop", 64'(a_sync), 64'(0));
        @(posedge clk); #1;
        check_val("t4_pulse_end", 64'(a_timeout), 64'(0));
        // A stale shift register would complete 00AAFF01 with this byte.
        send_a(8'h01);
        check_val("t4_no_stale_sync", 64'(a_sync), 64'(0));
        send_a_word(32'h1234_5678);
        check_val("t4_no_write_sync", 64'(a_sync), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check_val("a_words_left", 64'(a_wq.size()), 64'(0));
        check_val("a_acks_left", 64'(a_aq.size()), 64'(0));

        // Instance B: 16-bit words, no acknowledge.
        send_b(8'hAA); send_b(8'h01);
        check_val("t6_sync", 64'(b_sync), 64'(1));
        b_wq.push_back(16'h0010);
        send_b(8'h00); send_b(8'h10);
        check_val("t6_strobe", 64'(b_strobe), 64'(1));
        check_val("t6_wdata", 64'(b_wdata), 64'(16'h0010));
        check_val("t6_sync_drop", 64'(b_sync), 64'(0));
        check_val("t6_out_ready", 64'(b_out_ready), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check_val("b_words_left", 64'(b_wq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
